// File: rtl/out_sram_wb_receiver_pkg.sv
// Shared definitions for the output-SRAM write-back receiver: feature-vector
// sizing macros, node-id width, the per-bank request bundle and the FSM state
// type. Other files pull these in with import out_sram_wb_receiver_pkg::*.
`ifndef MAX_FV_num
`define MAX_FV_num 16
`endif
`ifndef Max_Node_id
`define Max_Node_id 16
`endif
`ifndef FV_size
`define FV_size 8
`endif

package out_sram_wb_receiver_pkg;

  localparam int NODE_ID_W = $clog2(`Max_Node_id);
  localparam int FV_W      = `FV_size;

  // One edge-buffer bank's view of the write-back channel. data packs two
  // feature values as {FV[1], FV[0]}.
  typedef struct packed {
    logic                 req;
    logic                 Grant_valid;
    logic                 sos;
    logic                 eos;
    logic [2*FV_W-1:0]    data;
    logic [NODE_ID_W-1:0] Node_id;
  } Bank_Req2Req_Output_SRAM;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RECV  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/out_sram_wb_receiver_rr_arbiter.sv
// Round-robin arbiter: the bank at ptr has highest priority, then ptr+1, ...
// The grant is combinational; the pointer only advances (to the bank after
// the accepted one) when the caller reports that the grant was taken up.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             accept,
  input  logic [IDX_W-1:0] accept_idx,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] ptr;

  function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= N) s = s - N;
    return IDX_W'(s);
  endfunction

  // Scan from the pointer and take the first requesting bank.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[wrap_idx(int'(ptr), i)]) begin
        any       = 1'b1;
        grant_idx = wrap_idx(int'(ptr), i);
      end
    end
    if (any) grant[grant_idx] = 1'b1;
  end

  // Priority pointer moves past a bank only once its stream has started.
  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else if (accept) ptr <= wrap_idx(int'(accept_idx), 1);
  end

endmodule

// File: rtl/out_sram_wb_receiver.sv
// Output-SRAM write-back receiver. Arbitrates between NUM_BANK edge-buffer
// banks and copies one node's 16-bit beats into SRAM at
// Node_id*WORDS_PER_NODE + beat.
// Optional build macro: OUT_SRAM_PROTO_CHK_EN enables the sticky proto_err
// flag (abort, overflow, sos in mid-stream); without it proto_err is 0.
//
// Handshake: req_grant[i] is high for exactly one cycle (GRANT). In that same
// cycle the bank answers with Grant_valid&&sos to start a stream; from then on
// every cycle with Grant_valid high transfers one beat and the beat carrying
// eos ends the stream. Grant_valid low mid-stream aborts it.
module out_sram_wb_receiver
  import out_sram_wb_receiver_pkg::*;
#(
  parameter int NUM_BANK       = 4,
  parameter int WORDS_PER_NODE = `MAX_FV_num / 2,
  parameter int ADDR_W         = $clog2(`Max_Node_id * WORDS_PER_NODE)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  Bank_Req2Req_Output_SRAM [NUM_BANK-1:0]  bank_pkt,
  output logic [NUM_BANK-1:0]                     req_grant,
  output logic                                    sram_wen,
  output logic [ADDR_W-1:0]                       sram_addr,
  output logic [15:0]                             sram_wdata,
  output logic                                    wb_done,
  output logic [NODE_ID_W-1:0]                    wb_node_id,
  output logic                                    busy,
  output logic                                    proto_err,
  output wb_state_e                               dbg_state
);

  localparam int PTR_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
  localparam int CNT_W = $clog2(WORDS_PER_NODE + 1);

  wb_state_e             state;
  logic [PTR_W-1:0]      win_idx;
  logic [CNT_W-1:0]      beat_cnt;
  logic [NODE_ID_W-1:0]  node_q;

  logic [NUM_BANK-1:0]   bank_req;
  logic [NUM_BANK-1:0]   arb_grant;
  logic [PTR_W-1:0]      arb_idx;
  logic                  arb_any;

  logic                  beat_ok;
  logic                  beat_last;
  logic                  beat_ovf;
  logic                  abort;
  logic                  accept_first;
  logic [NODE_ID_W-1:0]  beat_node;
  logic [CNT_W-1:0]      beat_k;
  logic [ADDR_W-1:0]     beat_addr;

  // Collect the request bits for the arbiter.
  always_comb begin
    bank_req = '0;
    for (int i = 0; i < NUM_BANK; i++) bank_req[i] = bank_pkt[i].req;
  end

  rr_arbiter #(
    .N     (NUM_BANK),
    .IDX_W (PTR_W)
  ) u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        (bank_req),
    .accept     (accept_first),
    .accept_idx (win_idx),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any        (arb_any)
  );

  // Decode the winner's beat for this cycle: is it accepted, which node and
  // beat index it belongs to, and whether it ends the stream.
  always_comb begin
    beat_ok   = 1'b0;
    abort     = 1'b0;
    beat_node = node_q;
    beat_k    = beat_cnt;
    case (state)
      ST_GRANT: begin
        beat_ok   = bank_pkt[win_idx].Grant_valid && bank_pkt[win_idx].sos;
        beat_node = bank_pkt[win_idx].Node_id;
        beat_k    = '0;
      end
      ST_RECV: begin
        beat_ok = bank_pkt[win_idx].Grant_valid;
        abort   = !bank_pkt[win_idx].Grant_valid;
      end
      default: ;
    endcase
    beat_last    = beat_ok && bank_pkt[win_idx].eos;
    beat_ovf     = beat_ok && !bank_pkt[win_idx].eos &&
                   (beat_k == CNT_W'(WORDS_PER_NODE - 1));
    accept_first = (state == ST_GRANT) && beat_ok;
    beat_addr    = ADDR_W'(beat_node) * ADDR_W'(WORDS_PER_NODE) + ADDR_W'(beat_k);
  end

  // Control FSM with registered grant, SRAM write port and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      req_grant  <= '0;
      win_idx    <= '0;
      beat_cnt   <= '0;
      node_q     <= '0;
      sram_wen   <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      wb_done    <= 1'b0;
      wb_node_id <= '0;
    end else begin
      sram_wen <= 1'b0;
      wb_done  <= 1'b0;
      if (beat_ok) begin
        sram_wen   <= 1'b1;
        sram_addr  <= beat_addr;
        sram_wdata <= bank_pkt[win_idx].data;
      end
      if (beat_last) begin
        wb_done    <= 1'b1;
        wb_node_id <= beat_node;
      end
      case (state)
        ST_IDLE: begin
          beat_cnt <= '0;
          if (arb_any) begin
            win_idx   <= arb_idx;
            req_grant <= arb_grant;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          req_grant <= '0;
          if (beat_ok) begin
            node_q   <= bank_pkt[win_idx].Node_id;
            beat_cnt <= CNT_W'(1);
            state    <= (beat_last || beat_ovf) ? ST_IDLE : ST_RECV;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RECV: begin
          if (abort || beat_last || beat_ovf) state <= ST_IDLE;
          else beat_cnt <= beat_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

`ifdef OUT_SRAM_PROTO_CHK_EN
  logic proto_evt;
  assign proto_evt = abort || beat_ovf ||
                     ((state == ST_RECV) && beat_ok && bank_pkt[win_idx].sos);

  // Sticky protocol error; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) proto_err <= 1'b0;
    else if (proto_evt) proto_err <= 1'b1;
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_out_sram_wb_receiver.sv
// Bench for out_sram_wb_receiver: bank behaviour models drive streams, a
// reference model predicts grants, SRAM writes, completions and proto_err.
`timescale 1ns/1ps
module tb_out_sram_wb_receiver;
  import out_sram_wb_receiver_pkg::*;

  localparam int NB       = 4;
  localparam int WPN      = `MAX_FV_num / 2;
  localparam int ADDR_W   = $clog2(`Max_Node_id * WPN);
  localparam int M_NORMAL = 0;
  localparam int M_DROP   = 1;
  localparam int M_NOEOS  = 2;
`ifdef OUT_SRAM_PROTO_CHK_EN
  localparam bit PROTO_EN = 1'b1;
`else
  localparam bit PROTO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  Bank_Req2Req_Output_SRAM [NB-1:0] bank_pkt;
  logic [NB-1:0]        req_grant;
  logic                 sram_wen;
  logic [ADDR_W-1:0]    sram_addr;
  logic [15:0]          sram_wdata;
  logic                 wb_done;
  logic [NODE_ID_W-1:0] wb_node_id;
  logic                 busy;
  logic                 proto_err;
  wb_state_e            dbg_state;

  out_sram_wb_receiver #(
    .NUM_BANK       (NB),
    .WORDS_PER_NODE (WPN),
    .ADDR_W         (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bank_pkt   (bank_pkt),
    .req_grant  (req_grant),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .wb_done    (wb_done),
    .wb_node_id (wb_node_id),
    .busy       (busy),
    .proto_err  (proto_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];     // {addr, data} of each expected SRAM write
  logic [31:0] done_q[$];    // node ids of expected completions
  int grant_log[$];
  int model_ptr;
  bit exp_proto;
  logic [NB-1:0] prev_req;
  logic [NB-1:0] prev_grant;

  int b_mode[NB];
  int b_len[NB];
  int b_refuse[NB];
  int b_beat[NB];
  bit b_pend[NB];
  bit b_act[NB];
  logic [NODE_ID_W-1:0] b_node[NB];
  logic [15:0] b_data[NB][16];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester at or after the pointer.
  function automatic logic [NB-1:0] rr_pick(input logic [NB-1:0] reqs, input int ptr);
    for (int i = 0; i < NB; i++) begin
      int b;
      b = (ptr + i) % NB;
      if (reqs[b]) return NB'(1) << b;
    end
    return '0;
  endfunction

  // ---------------- bank driver tasks ----------------
  task automatic idle_bank(input int b);
    bank_pkt[b].Grant_valid = 1'b0;
    bank_pkt[b].sos         = 1'($urandom_range(0, 1));
    bank_pkt[b].eos         = 1'($urandom_range(0, 1));
    bank_pkt[b].data        = 16'($urandom);
    bank_pkt[b].Node_id     = NODE_ID_W'($urandom);
  endtask

  task automatic present(input int b);
    int k;
    k = b_beat[b];
    if (k >= b_len[b]) begin
      b_act[b] = 1'b0;
      idle_bank(b);
    end else begin
      bank_pkt[b].Grant_valid = 1'b1;
      bank_pkt[b].sos         = (k == 0);
      bank_pkt[b].eos         = (b_mode[b] == M_NORMAL) && (k == b_len[b] - 1);
      bank_pkt[b].data        = b_data[b][k];
      bank_pkt[b].Node_id     = (k == 0) ? b_node[b] : NODE_ID_W'($urandom);
    end
  endtask

  // Writes a stream must produce: every beat up to eos, up to the abort,
  // or the first WPN beats of a stream that never sends eos.
  task automatic expect_stream(input int b);
    int n;
    int a;
    n = b_len[b];
    if (n > WPN) n = WPN;
    for (int k = 0; k < n; k++) begin
      a = int'(b_node[b]) * WPN + k;
      exp_q.push_back((32'(a) << 16) | 32'(b_data[b][k]));
    end
    if (b_mode[b] == M_NORMAL) done_q.push_back(32'(b_node[b]));
    else if (PROTO_EN) exp_proto = 1'b1;
  endtask

  task automatic set_stream(input int b, input int mode, input int len,
                            input int node, input int refuse, input bit fixed);
    b_mode[b]   = mode;
    b_len[b]    = len;
    b_node[b]   = NODE_ID_W'(node);
    b_refuse[b] = refuse;
    for (int k = 0; k < 16; k++)
      b_data[b][k] = fixed ? 16'(16'h0101 * (k + 1)) : 16'($urandom);
    b_pend[b]       = 1'b1;
    bank_pkt[b].req = 1'b1;
    prev_req[b]     = 1'b1;
  endtask

  task automatic clear_banks();
    for (int b = 0; b < NB; b++) begin
      b_pend[b] = 1'b0;
      b_act[b]  = 1'b0;
      b_beat[b] = 0;
      bank_pkt[b].req = 1'b0;
      idle_bank(b);
    end
    prev_req = '0;
  endtask

  task automatic monitor();
    if (prev_grant != '0) check_eq("grant_len", 32'(req_grant), 32'd0);
    if (req_grant != '0) begin
      check_eq("grant_pick", 32'(req_grant), 32'(rr_pick(prev_req, model_ptr)));
      for (int b = 0; b < NB; b++) if (req_grant[b]) grant_log.push_back(b);
    end
    if (sram_wen) begin
      if (exp_q.size() == 0) check_eq("wr_spurious", 32'(sram_wen), 32'd0);
      else check_eq("wr_addr_data", 32'({sram_addr, sram_wdata}), exp_q.pop_front());
    end
    if (wb_done) begin
      check_eq("done_with_wen", 32'(sram_wen), 32'd1);
      if (done_q.size() == 0) check_eq("done_spurious", 32'(wb_done), 32'd0);
      else check_eq("wb_node_id", 32'(wb_node_id), done_q.pop_front());
    end
    prev_grant = req_grant;
  endtask

  task automatic drive();
    logic [NB-1:0] rq;
    rq = '0;
    for (int b = 0; b < NB; b++) begin
      if (b_act[b]) begin
        b_beat[b]++;
        present(b);
      end else if (b_pend[b] && req_grant[b]) begin
        if (b_refuse[b] > 0) begin
          b_refuse[b]--;
          idle_bank(b);
        end else begin
          b_pend[b] = 1'b0;
          b_act[b]  = 1'b1;
          b_beat[b] = 0;
          model_ptr = (b + 1) % NB;
          expect_stream(b);
          present(b);
        end
      end else begin
        idle_bank(b);
      end
      bank_pkt[b].req = b_pend[b];
      rq[b] = b_pend[b];
    end
    prev_req = rq;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
    drive();
  endtask

  function automatic bit banks_busy();
    for (int b = 0; b < NB; b++) if (b_pend[b] || b_act[b]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_until_idle(input int budget);
    int c;
    c = 0;
    while ((banks_busy() || exp_q.size() != 0) && c < budget) begin
      tick();
      c++;
    end
    if (c >= budget) check_eq("timeout", 32'd1, 32'd0);
    repeat (3) tick();
    check_eq("exp_q_left", 32'(exp_q.size()), 32'd0);
    check_eq("done_q_left", 32'(done_q.size()), 32'd0);
    check_eq("busy_idle", 32'(busy), 32'd0);
    check_eq("proto_err", 32'(proto_err), 32'(exp_proto));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_banks();
    exp_q.delete();
    done_q.delete();
    exp_proto = 1'b0;
    model_ptr = 0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic check_zero_outputs();
    check_eq("rst_req_grant", 32'(req_grant), 32'd0);
    check_eq("rst_sram_wen", 32'(sram_wen), 32'd0);
    check_eq("rst_sram_addr", 32'(sram_addr), 32'd0);
    check_eq("rst_sram_wdata", 32'(sram_wdata), 32'd0);
    check_eq("rst_wb_done", 32'(wb_done), 32'd0);
    check_eq("rst_wb_node_id", 32'(wb_node_id), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_proto_err", 32'(proto_err), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    prev_grant = '0;
    clear_banks();
    do_reset();
    check_zero_outputs();

    // Single request, bank 1, node 3, 8 fixed beats -> addresses 24..31.
    set_stream(1, M_NORMAL, 8, 3, 0, 1'b1);
    run_until_idle(60);

    // Contention with pointer at 0: banks 0, 2, 3 served in that order.
    do_reset();
    grant_log.delete();
    set_stream(0, M_NORMAL, 3, 2, 0, 1'b0);
    set_stream(2, M_NORMAL, 4, 7, 0, 1'b0);
    set_stream(3, M_NORMAL, 2, 9, 0, 1'b0);
    run_until_idle(100);
    check_eq("order_count", 32'(grant_log.size()), 32'd3);
    if (grant_log.size() == 3) begin
      check_eq("order_0", 32'(grant_log[0]), 32'd0);
      check_eq("order_1", 32'(grant_log[1]), 32'd2);
      check_eq("order_2", 32'(grant_log[2]), 32'd3);
    end

    // Single-beat stream, node 5 -> one write at address 40.
    set_stream(2, M_NORMAL, 1, 5, 0, 1'b0);
    run_until_idle(30);

    // Grant_valid drops after two beats, node 1 -> writes at 8, 9 only.
    do_reset();
    set_stream(0, M_DROP, 2, 1, 0, 1'b0);
    run_until_idle(30);

    // Stream without eos -> only the first WPN beats are written.
    do_reset();
    set_stream(3, M_NOEOS, WPN + 2, 12, 0, 1'b0);
    run_until_idle(40);

    // Bank ignores its first two grants; it must be re-granted.
    do_reset();
    set_stream(2, M_NORMAL, 3, 6, 2, 1'b0);
    set_stream(3, M_NORMAL, 2, 4, 0, 1'b0);
    run_until_idle(60);

    // Reset while beat 4 of a stream is on the bus.
    do_reset();
    set_stream(1, M_NORMAL, 8, 10, 0, 1'b0);
    c = 0;
    while (!(b_act[1] && b_beat[1] == 4) && c < 40) begin
      tick();
      c++;
    end
    if (c >= 40) check_eq("timeout_mid", 32'd1, 32'd0);
    reset = 1'b1;
    clear_banks();
    exp_q.delete();
    done_q.delete();
    exp_proto = 1'b0;
    model_ptr = 0;
    tick();
    check_zero_outputs();
    reset = 1'b0;
    run_until_idle(10);

    // Randomized rounds; pointer and sticky proto_err carry across rounds.
    for (int r = 0; r < 12; r++) begin
      int m;
      int pend_cnt;
      pend_cnt = 0;
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 1) == 1 || (b == NB - 1 && pend_cnt == 0)) begin
          m = int'($urandom_range(0, 5));
          pend_cnt++;
          if (m <= 3)
            set_stream(b, M_NORMAL, int'($urandom_range(1, WPN)),
                       int'($urandom_range(0, `Max_Node_id - 1)),
                       int'($urandom_range(0, 1)), 1'b0);
          else if (m == 4)
            set_stream(b, M_DROP, int'($urandom_range(1, WPN - 1)),
                       int'($urandom_range(0, `Max_Node_id - 1)),
                       int'($urandom_range(0, 1)), 1'b0);
          else
            set_stream(b, M_NOEOS, int'($urandom_range(WPN + 1, WPN + 2)),
                       int'($urandom_range(0, `Max_Node_id - 1)),
                       int'($urandom_range(0, 1)), 1'b0);
        end
      end
      run_until_idle(200);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
